collision_detector: RTL

- Consumer of the dinosaur box outputs (x1/x2/y1/y2) and the obstacle generator's boxes.
- Once per animation frame it snapshots the dino box and accepts a serial stream of obstacle boxes over a valid/ready handshake.
- It decides whether any obstacle overlapped, debounces the result across consecutive frames, and latches game-over.
- It drives the game's animate enable and keeps a survived-frame score.

---
 rtl/collision_detector_pkg.sv | 39 +++
 rtl/collision_detector_if.sv | 25 ++
 rtl/collision_detector_box_overlap.sv | 15 +
 rtl/collision_detector.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/collision_detector_pkg.sv
// Shared types and default geometry for the collision detector, dinosaur and obstacle blocks.
package collision_detector_pkg;

    localparam int unsigned CoordW = 12;
    localparam int unsigned Margin = 2;

    typedef struct packed {
        logic [CoordW-1:0] x1;
        logic [CoordW-1:0] x2;
        logic [CoordW-1:0] y1;
        logic [CoordW-1:0] y2;
    } box_t;

    // One extra bit of headroom so the shrunk dino box cannot overflow.
    typedef struct packed {
        logic [CoordW:0] x1;
        logic [CoordW:0] x2;
        logic [CoordW:0] y1;
        logic [CoordW:0] y2;
    } wbox_t;

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StCollect,
        StDecide,
        StOver
    } state_e;

    function automatic wbox_t widen_box(box_t b);
        wbox_t w;
        w.x1 = {1'b0, b.x1};
        w.x2 = {1'b0, b.x2};
        w.y1 = {1'b0, b.y1};
        w.y2 = {1'b0, b.y2};
        return w;
    endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Obstacle box stream: valid/ready handshake with a last-of-frame marker.
interface collision_detector_if
    import collision_detector_pkg::*;
#(
    parameter int unsigned COORD_W = CoordW
);
    logic               obs_valid;
    logic               obs_last;
    logic               obs_ready;
    logic [COORD_W-1:0] obs_x1;
    logic [COORD_W-1:0] obs_x2;
    logic [COORD_W-1:0] obs_y1;
    logic [COORD_W-1:0] obs_y2;

    modport master (
        output obs_valid, obs_last, obs_x1, obs_x2, obs_y1, obs_y2,
        input  obs_ready
    );

    modport slave (
        input  obs_valid, obs_last, obs_x1, obs_x2, obs_y1, obs_y2,
        output obs_ready
    );

endinterface

// File: rtl/collision_detector_box_overlap.sv
// Strict (edge-exclusive) axis-aligned box overlap; a degenerate box never overlaps.
module collision_detector_box_overlap
    import collision_detector_pkg::*;
(
    input  wbox_t a_i,
    input  wbox_t b_i,
    input  logic  degen_i,
    output logic  overlap_o
);

    assign overlap_o = !degen_i &&
                       (a_i.x1 < b_i.x2) && (b_i.x1 < a_i.x2) &&
                       (a_i.y1 < b_i.y2) && (b_i.y1 < a_i.y2);

endmodule

// File: rtl/collision_detector.sv
// Per-frame dino/obstacle collision check with hit debounce, game-over latch and score.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int unsigned COORD_W    = CoordW,
    parameter int unsigned HIT_FRAMES = 2,
    parameter int unsigned MARGIN     = Margin,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ani_stb,
    input  logic                 i_restart,
    input  logic [COORD_W-1:0]   i_dino_x1,
    input  logic [COORD_W-1:0]   i_dino_x2,
    input  logic [COORD_W-1:0]   i_dino_y1,
    input  logic [COORD_W-1:0]   i_dino_y2,
    collision_detector_if.slave  obs_if,
    output logic                 o_hit,
    output logic                 o_overrun,
    output logic                 o_game_over,
    output logic                 o_animate,
    output logic [SCORE_W-1:0]   o_score
);

    // Box structs are sized by the package constant.
    if (COORD_W != CoordW) begin : g_bad_coord_w
        $error("COORD_W must match collision_detector_pkg::CoordW");
    end

    localparam logic [COORD_W:0] MarginW = (COORD_W+1)'(MARGIN);
    localparam logic [3:0]       HitMax  = 4'(HIT_FRAMES);

    state_e             state_q, state_d;
    wbox_t              dbox_q, dbox_d;
    logic               degen_q, degen_d;
    logic               frame_hit_q, frame_hit_d;
    logic [3:0]         hit_cnt_q, hit_cnt_d;
    logic               hit_q, hit_d;
    logic               overrun_q, overrun_d;
    logic               game_over_q, game_over_d;
    logic [SCORE_W-1:0] score_q, score_d;

    wbox_t snap_box;
    wbox_t obs_box;
    logic  snap_degen;
    logic  obs_ready;
    logic  accept;
    logic  overlap;

    assign obs_ready        = (state_q == StCollect);
    assign obs_if.obs_ready = obs_ready;
    assign accept           = obs_if.obs_valid && obs_ready;

    always_comb begin
        obs_box.x1 = {1'b0, obs_if.obs_x1};
        obs_box.x2 = {1'b0, obs_if.obs_x2};
        obs_box.y1 = {1'b0, obs_if.obs_y1};
        obs_box.y2 = {1'b0, obs_if.obs_y2};
        snap_box.x1 = {1'b0, i_dino_x1} + MarginW;
        snap_box.x2 = {1'b0, i_dino_x2} - MarginW;
        snap_box.y1 = {1'b0, i_dino_y1} + MarginW;
        snap_box.y2 = {1'b0, i_dino_y2} - MarginW;
        // The far-edge checks catch x2/y2 - MARGIN wrapping below zero.
        snap_degen = (snap_box.x1 >= snap_box.x2) || (snap_box.y1 >= snap_box.y2) ||
                     ({1'b0, i_dino_x2} < MarginW) || ({1'b0, i_dino_y2} < MarginW);
    end

    collision_detector_box_overlap u_box_overlap (
        .a_i       (dbox_q),
        .b_i       (obs_box),
        .degen_i   (degen_q),
        .overlap_o (overlap)
    );

    always_comb begin
        state_d     = state_q;
        dbox_d      = dbox_q;
        degen_d     = degen_q;
        frame_hit_d = frame_hit_q;
        hit_cnt_d   = hit_cnt_q;
        hit_d       = 1'b0;
        overrun_d   = 1'b0;
        game_over_d = game_over_q;
        score_d     = score_q;
        unique case (state_q)
            StIdle: begin
                if (i_ani_stb) state_d = StSnap;
            end
            StSnap: begin
                dbox_d      = snap_box;
                degen_d     = snap_degen;
                frame_hit_d = 1'b0;
                state_d     = StCollect;
            end
            StCollect: begin
                if (accept) frame_hit_d = frame_hit_q | overlap;
                if (accept && obs_if.obs_last) begin
                    state_d = StDecide;
                end else if (i_ani_stb) begin
                    overrun_d = 1'b1;
                    state_d   = StDecide;
                end
            end
            StDecide: begin
                if (frame_hit_q) begin
                    hit_d     = 1'b1;
                    hit_cnt_d = (hit_cnt_q >= HitMax) ? HitMax : hit_cnt_q + 4'd1;
                    if (hit_cnt_d == HitMax) begin
                        game_over_d = 1'b1;
                        state_d     = StOver;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hit_cnt_d = '0;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                    state_d = StIdle;
                end
            end
            StOver: begin
                if (i_restart) begin
                    game_over_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_restart) begin
            hit_cnt_d = '0;
            score_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            dbox_q      <= '0;
            degen_q     <= 1'b0;
            frame_hit_q <= 1'b0;
            hit_cnt_q   <= '0;
            hit_q       <= 1'b0;
            overrun_q   <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            dbox_q      <= dbox_d;
            degen_q     <= degen_d;
            frame_hit_q <= frame_hit_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_q       <= hit_d;
            overrun_q   <= overrun_d;
            game_over_q <= game_over_d;
            score_q     <= score_d;
        end
    end

    assign o_hit       = hit_q;
    assign o_overrun   = overrun_q;
    assign o_game_over = game_over_q;
    assign o_animate   = ~game_over_q;
    assign o_score     = score_q;

endmodule
